// File: rtl/bp_cce_pending_bits_if.sv
// Request/response bundle between the CCE decode stage and the pending-bit block.
// Signal names carry the direction seen from the pending-bit block.
interface bp_cce_pending_bits_if #(
   parameter int paddr_width_p = 40,
   parameter int cnt_width_p   = 4
);
   logic                     w_v_i;
   logic [paddr_width_p-1:0] w_addr_i;
   logic                     w_inc_i;
   logic                     w_clr_i;
   logic                     r_v_i;
   logic [paddr_width_p-1:0] r_addr_i;
   logic                     stall_i;
   logic                     pending_v_o;
   logic                     pending_o;
   logic [cnt_width_p-1:0]   cnt_o;
   logic                     overflow_o;
   logic                     underflow_o;

   // Handshake: a request is taken on a clock edge when its valid is high
   // and stall_i is low; there is no ready, and a read answers exactly one
   // cycle later with a single-cycle pending_v_o pulse.
   modport master (
      output w_v_i, w_addr_i, w_inc_i, w_clr_i, r_v_i, r_addr_i, stall_i,
      input  pending_v_o, pending_o, cnt_o, overflow_o, underflow_o
   );

   modport slave (
      input  w_v_i, w_addr_i, w_inc_i, w_clr_i, r_v_i, r_addr_i, stall_i,
      output pending_v_o, pending_o, cnt_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/bp_cce_pending_bits.sv
// Per-way-group saturating pending-transaction counters with a registered
// read port; a write to the group being read in the same cycle is forwarded.
module bp_cce_pending_bits #(
   parameter int paddr_width_p            = 40,
   parameter int lg_block_size_in_bytes_p = 6,
   parameter int num_way_groups_p         = 64,
   parameter int cnt_width_p              = 4
) (
   input logic                  clk_i,
   input logic                  reset_i,
   bp_cce_pending_bits_if.slave bus
);
   localparam int lg_wg_lp = $clog2(num_way_groups_p);
   localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

   logic [cnt_width_p-1:0] r_cnt [num_way_groups_p];
   logic                   r_pending_v;
   logic                   r_pending;
   logic [cnt_width_p-1:0] r_cnt_out;
   logic                   r_overflow;
   logic                   r_underflow;

   logic [lg_wg_lp-1:0]    w_w_wg;
   logic [lg_wg_lp-1:0]    w_r_wg;
   logic                   w_w_en;
   logic                   w_r_en;
   logic [cnt_width_p-1:0] w_w_cur;
   logic [cnt_width_p-1:0] w_w_next;
   logic                   w_ovf;
   logic                   w_unf;
   logic [cnt_width_p-1:0] w_r_val;
   logic                   w_unused_addr;

   // Upper address bits alias onto the same group; block offset is dropped.
   assign w_w_wg = bus.w_addr_i[lg_block_size_in_bytes_p +: lg_wg_lp];
   assign w_r_wg = bus.r_addr_i[lg_block_size_in_bytes_p +: lg_wg_lp];
   assign w_unused_addr = ^{bus.w_addr_i, bus.r_addr_i};

   assign w_w_en  = bus.w_v_i & ~bus.stall_i;
   assign w_r_en  = bus.r_v_i & ~bus.stall_i;
   assign w_w_cur = r_cnt[w_w_wg];

   always_comb begin
      w_w_next = w_w_cur;
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
      if (bus.w_clr_i) begin
         w_w_next = '0;
      end else if (bus.w_inc_i) begin
         if (w_w_cur == cnt_max_lp) w_ovf = 1'b1;
         else                       w_w_next = w_w_cur + cnt_width_p'(1);
      end else begin
         if (w_w_cur == '0) w_unf = 1'b1;
         else               w_w_next = w_w_cur - cnt_width_p'(1);
      end
   end

   // Read sees the post-write value when both ports hit the same group.
   assign w_r_val = (w_w_en && (w_w_wg == w_r_wg)) ? w_w_next : r_cnt[w_r_wg];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < num_way_groups_p; i++) r_cnt[i] <= '0;
         r_pending_v <= 1'b0;
         r_pending   <= 1'b0;
         r_cnt_out   <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_w_en) r_cnt[w_w_wg] <= w_w_next;
         r_overflow  <= r_overflow  | (w_w_en & w_ovf);
         r_underflow <= r_underflow | (w_w_en & w_unf);
         r_pending_v <= w_r_en;
         if (w_r_en) begin
            r_cnt_out <= w_r_val;
            r_pending <= (w_r_val != '0);
         end
      end
   end

   assign bus.pending_v_o = r_pending_v;
   assign bus.pending_o   = r_pending;
   assign bus.cnt_o       = r_cnt_out;
   assign bus.overflow_o  = r_overflow;
   assign bus.underflow_o = r_underflow;
endmodule

// File: tb/tb_bp_cce_pending_bits.sv
// Bench for bp_cce_pending_bits: hand vector table, corner sequences and
// random traffic compared against an integer counter model.
module tb_bp_cce_pending_bits;
   localparam int PW  = 40;
   localparam int CW  = 4;
   localparam int NWG = 64;
   localparam int LGB = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bp_cce_pending_bits_if #(.paddr_width_p(PW), .cnt_width_p(CW)) bus ();

   bp_cce_pending_bits #(
      .paddr_width_p(PW), .lg_block_size_in_bytes_p(LGB),
      .num_way_groups_p(NWG), .cnt_width_p(CW)
   ) dut (
      .clk_i(clk), .reset_i(reset), .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;

   int m_cnt [NWG];
   int m_rd;
   bit m_v, m_ovf, m_unf;

   typedef struct {
      bit             wv;
      logic [PW-1:0]  wa;
      bit             inc;
      bit             clr;
      bit             rv;
      logic [PW-1:0]  ra;
      bit             st;
      bit             ev;
      int             ecnt;
   } vec_t;
   vec_t tbl [20];

   function automatic int wg_of(input logic [PW-1:0] a);
      return int'((a >> LGB) % NWG);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NWG; i++) m_cnt[i] = 0;
      m_rd = 0; m_v = 0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_v"},    int'(bus.pending_v_o), int'(m_v));
      check({tag, "_cnt"},  int'(bus.cnt_o),       m_rd);
      check({tag, "_pend"}, int'(bus.pending_o),   int'(m_rd != 0));
      check({tag, "_ovf"},  int'(bus.overflow_o),  int'(m_ovf));
      check({tag, "_unf"},  int'(bus.underflow_o), int'(m_unf));
   endtask

   // Called at a negedge: apply inputs, advance the model, compare at the next negedge.
   task automatic drive(input bit wv, input logic [PW-1:0] wa, input bit inc,
                        input bit clr, input bit rv, input logic [PW-1:0] ra,
                        input bit st, input string tag);
      int wi;
      int ri;
      bus.w_v_i = wv; bus.w_addr_i = wa; bus.w_inc_i = inc; bus.w_clr_i = clr;
      bus.r_v_i = rv; bus.r_addr_i = ra; bus.stall_i = st;
      wi = wg_of(wa);
      ri = wg_of(ra);
      if (wv && !st) begin
         if (clr)                 m_cnt[wi] = 0;
         else if (inc) begin
            if (m_cnt[wi] == CMAX) m_ovf = 1;
            else                   m_cnt[wi]++;
         end else begin
            if (m_cnt[wi] == 0)    m_unf = 1;
            else                   m_cnt[wi]--;
         end
      end
      m_v = rv && !st;
      if (m_v) m_rd = m_cnt[ri];
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      drive(0, '0, 0, 0, 0, '0, 0, tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      bus.w_v_i = 0; bus.r_v_i = 0; bus.stall_i = 0;
      @(negedge clk);
      model_reset();
      reset = 1'b0;
      check_model(tag);
   endtask

   initial begin
      logic [PW-1:0] a;
      logic [PW-1:0] b;

      reset = 1'b1;
      bus.w_v_i = 0; bus.w_addr_i = '0; bus.w_inc_i = 0; bus.w_clr_i = 0;
      bus.r_v_i = 0; bus.r_addr_i = '0; bus.stall_i = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_model("reset");
      reset = 1'b0;

      //            wv  wa         inc clr rv  ra         st  ev ecnt
      tbl[0]  = '{0, 40'h0,     0, 0, 1, 40'h0,    0, 1, 0};
      tbl[1]  = '{1, 40'h1040,  1, 0, 0, 40'h0,    0, 0, 0};
      tbl[2]  = '{1, 40'h1040,  1, 0, 0, 40'h0,    0, 0, 0};
      tbl[3]  = '{1, 40'h1040,  1, 0, 0, 40'h0,    0, 0, 0};
      tbl[4]  = '{0, 40'h0,     0, 0, 1, 40'h1040, 0, 1, 3};
      tbl[5]  = '{0, 40'h0,     0, 0, 1, 40'h1000, 0, 1, 0};
      tbl[6]  = '{1, 40'h40,    0, 0, 1, 40'h40,   0, 1, 2};
      tbl[7]  = '{1, 40'h1040,  0, 0, 1, 40'h1040, 0, 1, 1};
      tbl[8]  = '{0, 40'h0,     0, 0, 1, 40'h1040, 0, 1, 1};
      tbl[9]  = '{1, 40'h1040,  1, 0, 1, 40'h1040, 1, 0, 1};
      tbl[10] = '{1, 40'h1040,  1, 0, 1, 40'h1040, 0, 1, 2};
      tbl[11] = '{0, 40'h0,     0, 0, 1, 40'h40,   0, 1, 2};
      tbl[12] = '{1, 40'h80,    1, 0, 0, 40'h0,    0, 0, 2};
      tbl[13] = '{1, 40'h80,    1, 0, 0, 40'h0,    0, 0, 2};
      tbl[14] = '{1, 40'h80,    1, 0, 0, 40'h0,    0, 0, 2};
      tbl[15] = '{1, 40'h80,    1, 0, 0, 40'h0,    0, 0, 2};
      tbl[16] = '{1, 40'h80,    1, 0, 1, 40'h80,   0, 1, 5};
      tbl[17] = '{1, 40'h80,    1, 1, 1, 40'h80,   0, 1, 0};
      tbl[18] = '{1, 40'h1040,  1, 0, 1, 40'h80,   0, 1, 0};
      tbl[19] = '{0, 40'h0,     0, 0, 1, 40'h1040, 0, 1, 3};

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].wv, tbl[i].wa, tbl[i].inc, tbl[i].clr,
               tbl[i].rv, tbl[i].ra, tbl[i].st, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_exp_v", i),   int'(bus.pending_v_o), int'(tbl[i].ev));
         check($sformatf("tbl%0d_exp_cnt", i), int'(bus.cnt_o),       tbl[i].ecnt);
         check($sformatf("tbl%0d_no_ovf", i),  int'(bus.overflow_o),  0);
      end

      // Saturation at the top, then underflow on an empty group; flags stick.
      for (int i = 0; i < 16; i++) drive(1, 40'hC0, 1, 0, 0, '0, 0, "sat_inc");
      drive(0, '0, 0, 0, 1, 40'hC0, 0, "sat_rd");
      check("sat_cnt15", int'(bus.cnt_o), CMAX);
      check("sat_ovf", int'(bus.overflow_o), 1);
      drive(1, 40'h100, 0, 0, 1, 40'h100, 0, "unf_dec");
      check("unf_cnt0", int'(bus.cnt_o), 0);
      check("unf_flag", int'(bus.underflow_o), 1);
      for (int i = 0; i < 4; i++) idle("sticky");
      check("sticky_ovf", int'(bus.overflow_o), 1);
      check("sticky_unf", int'(bus.underflow_o), 1);
      do_reset("flag_rst");

      // Read accepted, then reset on the next cycle together with another read.
      drive(1, 40'h40, 1, 0, 1, 40'h40, 0, "pre_rst");
      check("pre_rst_cnt1", int'(bus.cnt_o), 1);
      bus.r_v_i = 1; bus.r_addr_i = 40'h40; bus.w_v_i = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check("rst_dom_v", int'(bus.pending_v_o), 0);
      check_model("rst_dom");
      drive(0, '0, 0, 0, 1, 40'h40, 0, "post_rst_rd");

      // Random traffic over a few groups with aliased upper bits.
      for (int i = 0; i < 600; i++) begin
         if (i % 200 == 199) do_reset("rnd_rst");
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         a[11:6] = 6'($urandom_range(0, 3));
         b[11:6] = ($urandom_range(0, 1) == 0) ? a[11:6] : 6'($urandom_range(0, 3));
         drive(1'($urandom_range(0, 1)), a, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), b,
               $urandom_range(0, 4) == 0, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
